dbus_arbiter: RTL and testbench

//  Two-master, one-slave arbiter and sequencer for the shared data bus behind the core.
//  M0 is the core load/store port. M1 is the debug/program-loader port.

---
 rtl/dbus_arbiter.sv | 127 ++++++++++++
 tb/tb_dbus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-master, one-slave data-bus arbiter: round-robin on ties, fixed wait-state
// slave access, one-cycle ack with captured read data, and a stall to the core.
module dbus_arbiter #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ack,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_stall,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                s_en,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_rdata,

    output logic                grant_id
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t             state;
    logic               last_gnt;
    logic [CNT_W-1:0]   cnt;

    logic               winner;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [STRB_W-1:0]  sel_wstrb;

    // A tie goes to the master that did not win the previous tie.
    always_comb begin
        winner    = (m0_req & m1_req) ? ~last_gnt : m1_req;
        sel_we    = winner ? m1_we    : m0_we;
        sel_addr  = winner ? m1_addr  : m0_addr;
        sel_wdata = winner ? m1_wdata : m0_wdata;
        sel_wstrb = winner ? m1_wstrb : m0_wstrb;
    end

    assign m0_stall = m0_req & ~m0_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            cnt      <= '0;
            grant_id <= 1'b0;
            s_en     <= 1'b0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req | m1_req) begin
                        grant_id <= winner;
                        if (m0_req & m1_req) begin
                            last_gnt <= winner;
                        end
                        s_en    <= 1'b1;
                        s_we    <= sel_we;
                        s_addr  <= sel_addr;
                        s_wdata <= sel_wdata;
                        s_wstrb <= sel_we ? sel_wstrb : '0;
                        cnt     <= CNT_W'(WAIT_CYCLES);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        s_en  <= 1'b0;
                        state <= ACK;
                        if (grant_id) begin
                            m1_rdata <= s_rdata;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= s_rdata;
                            m0_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench for dbus_arbiter against a timestamp-based transaction model,
// plus a directed zero-wait-state check on a second instance.
module tb_dbus_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req   [2];
    logic        we    [2];
    logic [7:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  strb  [2];
    logic [31:0] s_rdata;

    logic        m0_ack, m1_ack, m0_stall, s_en, s_we, grant_id;
    logic [31:0] m0_rdata, m1_rdata, s_wdata;
    logic [7:0]  s_addr;
    logic [3:0]  s_wstrb;

    dbus_arbiter #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_wstrb(strb[0]),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_wstrb(strb[1]),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .grant_id(grant_id)
    );

    // zero-wait-state instance
    logic        z_m0_req, z_m0_we, z_m1_req, z_m1_we;
    logic [7:0]  z_m0_addr, z_m1_addr, z_s_addr;
    logic [31:0] z_m0_wdata, z_m1_wdata, z_s_rdata, z_m0_rdata, z_m1_rdata, z_s_wdata;
    logic [3:0]  z_m0_wstrb, z_m1_wstrb, z_s_wstrb;
    logic        z_m0_ack, z_m1_ack, z_m0_stall, z_s_en, z_s_we, z_grant_id;

    dbus_arbiter #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(z_m0_req), .m0_we(z_m0_we), .m0_addr(z_m0_addr), .m0_wdata(z_m0_wdata), .m0_wstrb(z_m0_wstrb),
        .m0_ack(z_m0_ack), .m0_rdata(z_m0_rdata), .m0_stall(z_m0_stall),
        .m1_req(z_m1_req), .m1_we(z_m1_we), .m1_addr(z_m1_addr), .m1_wdata(z_m1_wdata), .m1_wstrb(z_m1_wstrb),
        .m1_ack(z_m1_ack), .m1_rdata(z_m1_rdata),
        .s_en(z_s_en), .s_we(z_s_we), .s_addr(z_s_addr), .s_wdata(z_s_wdata), .s_wstrb(z_s_wstrb),
        .s_rdata(z_s_rdata), .grant_id(z_grant_id)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: each grant at edge g occupies the slave for edges g..g+W, acks after edge g+W+1,
    // and the bus may be sampled again from edge g+W+3.
    int          k, g, next_free;
    bit          act, e_last, e_gid, e_we, mw;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_rd [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; g = 0; next_free = 0; act = 0; e_last = 1; e_gid = 0;
            e_we = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0; e_rd[0] = 0; e_rd[1] = 0;
        end else begin
            k++;
            if (act && (k - g) == W + 1) e_rd[e_gid] = s_rdata;
            if (k >= next_free && (req[0] || req[1])) begin
                if (req[0] && req[1]) begin
                    mw = !e_last;
                    e_last = mw;
                end else begin
                    mw = req[1];
                end
                e_gid = mw; e_we = we[mw]; e_addr = addr[mw]; e_wdata = wdata[mw];
                e_wstrb = we[mw] ? strb[mw] : 4'h0;
                g = k; next_free = k + W + 3; act = 1;
            end
        end
    end

    task automatic check_all();
        bit en_x, ack0_x, ack1_x;
        en_x   = act && (k - g) <= W;
        ack0_x = act && (k - g) == W + 1 && e_gid == 1'b0;
        ack1_x = act && (k - g) == W + 1 && e_gid == 1'b1;
        check("s_en", s_en, en_x);
        check("m0_ack", m0_ack, ack0_x);
        check("m1_ack", m1_ack, ack1_x);
        check("grant_id", grant_id, e_gid);
        check("s_we", s_we, e_we);
        check("s_addr", s_addr, e_addr);
        check("s_wdata", s_wdata, e_wdata);
        check("s_wstrb", s_wstrb, e_wstrb);
        check("m0_rdata", m0_rdata, e_rd[0]);
        check("m1_rdata", m1_rdata, e_rd[1]);
        check("m0_stall", m0_stall, req[0] && !ack0_x);
    endtask

    bit waiting [2];

    task automatic new_txn(input int x);
        waiting[x] = 1;
        req[x]   = 1'b1;
        we[x]    = 1'($urandom);
        addr[x]  = 8'($urandom);
        wdata[x] = $urandom;
        strb[x]  = 4'($urandom);
    endtask

    task automatic drive();
        logic ackx;
        s_rdata = $urandom;
        for (int x = 0; x < 2; x++) begin
            ackx = (x == 0) ? m0_ack : m1_ack;
            if (waiting[x]) begin
                if (ackx) begin
                    waiting[x] = 0;
                    req[x] = 1'b0;
                end else if (req[x] && s_en && grant_id == 1'(x) && $urandom_range(0, 7) == 0) begin
                    req[x] = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_txn(x);
            end
        end
    endtask

    initial begin
        int inj_left, next_inj;
        rst_n = 1'b0;
        s_rdata = '0;
        for (int x = 0; x < 2; x++) begin
            req[x] = 0; we[x] = 0; addr[x] = 0; wdata[x] = 0; strb[x] = 0; waiting[x] = 0;
        end
        z_m0_req = 0; z_m0_we = 0; z_m0_addr = 0; z_m0_wdata = 0; z_m0_wstrb = 0;
        z_m1_req = 0; z_m1_we = 0; z_m1_addr = 0; z_m1_wdata = 0; z_m1_wstrb = 0;
        z_s_rdata = 0;

        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        new_txn(0);
        new_txn(1);

        inj_left = 3;
        next_inj = 300;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check_all();
            if (!rst_n) begin
                rst_n = 1'b1;
                for (int x = 0; x < 2; x++) begin
                    if (!req[x]) waiting[x] = 0;
                    if (!waiting[x]) new_txn(x);
                end
                continue;
            end
            drive();
            // async reset in the first ACCESS cycle of a fresh grant
            if (inj_left > 0 && cyc >= next_inj && act && k == g) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_s_en", s_en, 1'b0);
                check("rst_acks", {m1_ack, m0_ack}, 2'b00);
                inj_left--;
                next_inj = cyc + 700;
            end
        end

        req[0] = 0; req[1] = 0;
        @(negedge clk);
        z_m0_req = 1; z_m0_we = 0; z_m0_addr = 8'h22; z_m0_wstrb = 4'hF;
        z_m0_wdata = 32'hCAFE0001; z_s_rdata = 32'h12345678;
        @(negedge clk);
        check("w0_s_en", z_s_en, 1'b1);
        check("w0_s_wstrb", z_s_wstrb, 4'h0);
        check("w0_s_we", z_s_we, 1'b0);
        check("w0_s_addr", z_s_addr, 8'h22);
        check("w0_ack_early", z_m0_ack, 1'b0);
        check("w0_stall", z_m0_stall, 1'b1);
        @(negedge clk);
        check("w0_ack", z_m0_ack, 1'b1);
        check("w0_rdata", z_m0_rdata, 32'h12345678);
        check("w0_s_en_off", z_s_en, 1'b0);
        check("w0_m1_ack", z_m1_ack, 1'b0);
        z_m0_req = 0;
        @(negedge clk);
        check("w0_ack_once", z_m0_ack, 1'b0);
        check("w0_idle_en", z_s_en, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
